apb_mst_bridge: RTL and testbench

//  APB requester: turns one command from a local valid/ready port into one APB transfer
//  (SETUP then ACCESS), waits for PREADY, returns read data and error status on a response port.

---
 rtl/apb_mst_bridge.sv | 137 +++++++++++++
 tb/tb_apb_mst_bridge.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_mst_bridge.sv
// APB requester bridge: one local command in, one APB SETUP/ACCESS transfer out,
// one response back. A single transfer is in flight at a time. A wait counter
// aborts transfers whose responder never raises PREADY.
//
// Handshakes: a local transfer happens on a rising edge where valid and ready
// are both high. The bridge raises cmd_ready only in IDLE, and it holds rsp_valid
// and every rsp_* field stable until it sees rsp_ready.
module apb_mst_bridge #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_SIZE-1:0]   cmd_addr,
  input  logic [DATA_SIZE-1:0]   cmd_wdata,
  input  logic [DATA_SIZE/8-1:0] cmd_strobe,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic                   rsp_timeout,
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic [DATA_SIZE/8-1:0] PSTROBE,
  input  logic                   PREADY,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PSLVERR
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // The state is kept as a named enum so that checkers can bind to it.
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] wait_cnt;
  logic          timeout_hit;
  logic          psel_d;
  logic          penable_d;
  logic          rsp_valid_d;

  assign cmd_ready = (state == IDLE);

  // Last ACCESS cycle that may still run without PREADY has been reached.
  assign timeout_hit = (state == ACCESS) && !PREADY && (wait_cnt == CNT_LAST);

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode of the next state, so the registered outputs track the state
  always_comb begin
    psel_d      = (state_next == SETUP) || (state_next == ACCESS);
    penable_d   = (state_next == ACCESS);
    rsp_valid_d = (state_next == RESP);
  end

  // Output register for the APB control lines and rsp_valid; reset drops them at once
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  // ACCESS wait counter: cleared in SETUP, stops at the limit because ACCESS exits there
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Request latch on accept. Reads drive no strobes. The fields hold after the transfer.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR   <= '0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTROBE <= '0;
    end else if ((state == IDLE) && cmd_valid) begin
      PADDR   <= cmd_addr;
      PWRITE  <= cmd_write;
      PWDATA  <= cmd_wdata;
      PSTROBE <= cmd_write ? cmd_strobe : '0;
    end
  end

  // Response capture at the end of ACCESS, either completed or aborted
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else if ((state == ACCESS) && PREADY) begin
      rsp_rdata   <= PWRITE ? '0 : PRDATA;
      rsp_err     <= PSLVERR;
      rsp_timeout <= 1'b0;
    end else if (timeout_hit) begin
      rsp_rdata   <= '0;
      rsp_err     <= 1'b1;
      rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_mst_bridge.sv
// Bench for apb_mst_bridge: directed scenarios followed by randomized transfers.
// The expected outcome of each transfer is derived from the responder's wait count,
// and the expected responses are kept in a queue.
module tb_apb_mst_bridge;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int TO = 16;
  localparam int SW = DW / 8;
  localparam int RW = DW + 2;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strobe;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTROBE;
  logic          PREADY;
  logic [DW-1:0] PRDATA;
  logic          PSLVERR;

  apb_mst_bridge #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strobe(cmd_strobe),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTROBE(PSTROBE), .PREADY(PREADY), .PRDATA(PRDATA),
    .PSLVERR(PSLVERR)
  );

  // Clock
  always #5 PCLK = ~PCLK;

  // Scoreboard state
  logic [RW-1:0] exp_q[$];
  int            passed = 0;
  int            total  = 0;

  // Command currently in flight, recorded by the driver
  logic          cur_w;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [SW-1:0] cur_strb;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one command at a falling edge and leave after the accepting rising edge
  task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    cur_w = w; cur_addr = a; cur_wdata = d; cur_strb = s;
    cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strobe = s;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge PCLK);
    cmd_valid = 1'b0;
  endtask

  // Act as the responder: raise PREADY after wait_n wait cycles. If wait_n >= TO,
  // PREADY is never raised. Then check the transfer shape and the response.
  task automatic serve(input int wait_n, input logic [DW-1:0] rd, input logic err);
    int            n_acc;
    int            psel_n;
    int            pen_n;
    int            steps;
    logic          seen;
    logic          stable_ok;
    logic [SW-1:0] exp_strb;
    logic [RW-1:0] exp_rsp;
    n_acc     = (wait_n + 1 < TO) ? wait_n + 1 : TO;
    exp_strb  = cur_w ? cur_strb : '0;
    if (wait_n >= TO) exp_q.push_back({1'b1, 1'b1, {DW{1'b0}}});
    else              exp_q.push_back({1'b0, err, cur_w ? {DW{1'b0}} : rd});
    psel_n = 0; pen_n = 0; steps = 0; seen = 1'b0; stable_ok = 1'b1;
    check("setup_phase", 64'({PSEL, PENABLE}), 64'b10);
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (PSEL) psel_n++;
      if (PADDR !== cur_addr || PWRITE !== cur_w || PWDATA !== cur_wdata ||
          PSTROBE !== exp_strb) stable_ok = 1'b0;
      if (PSEL && PENABLE) begin
        pen_n++;
        PREADY  = (pen_n == wait_n + 1);
        PRDATA  = PREADY ? rd : $urandom;
        PSLVERR = PREADY ? err : 1'($urandom_range(0, 1));
      end else begin
        PREADY  = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom_range(0, 1));
      end
      @(negedge PCLK);
      steps++;
    end
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    check("rsp_seen", 64'(seen), 64'd1);
    check("psel_cycles", 64'(psel_n), 64'(n_acc + 1));
    check("penable_cycles", 64'(pen_n), 64'(n_acc));
    check("latency", 64'(steps + 1), 64'(n_acc + 2));
    check("fields_stable", 64'(stable_ok), 64'd1);
    check("apb_idle_in_resp", 64'({PSEL, PENABLE}), 64'b00);
    check("pstrobe_hold", 64'(PSTROBE), 64'(exp_strb));
    check("paddr_hold", 64'(PADDR), 64'(cur_addr));
    exp_rsp = exp_q.pop_front();
    check("rsp_fields", 64'({rsp_timeout, rsp_err, rsp_rdata}), 64'(exp_rsp));
  endtask

  // Hold off the response for delay cycles, then take it
  task automatic take_rsp(input int delay);
    logic [RW-1:0] snap;
    snap = {rsp_timeout, rsp_err, rsp_rdata};
    for (int i = 0; i < delay; i++) begin
      rsp_ready = 1'b0;
      @(negedge PCLK);
      check("rsp_hold_ctrl", 64'({rsp_valid, cmd_ready, PSEL, PENABLE}), 64'b1000);
      check("rsp_hold_data", 64'({rsp_timeout, rsp_err, rsp_rdata}), 64'(snap));
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("rsp_release", 64'({rsp_valid, cmd_ready}), 64'b01);
  endtask

  initial begin
    PRESET = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strobe = '0;
    rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);

    // Reset state
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_ctrl", 64'({PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout}), 64'd0);
    check("reset_data", 64'({PADDR, PSTROBE, rsp_rdata}), 64'd0);
    check("reset_pwdata", 64'(PWDATA), 64'd0);

    // Write, two wait cycles
    send_cmd(1'b1, 6'd5, 32'hA5A5_1234, 4'b0011);
    serve(2, 32'h0, 1'b0);
    take_rsp(0);

    // Zero-wait read; a nonzero cmd_strobe must not reach PSTROBE
    send_cmd(1'b0, 6'd9, 32'h1111_2222, 4'b1111);
    serve(0, 32'hDEAD_BEEF, 1'b0);
    take_rsp(1);

    // Read that the responder completes with an error
    send_cmd(1'b0, 6'd40, 32'h0, 4'b0000);
    serve(0, 32'h0, 1'b1);
    take_rsp(0);

    // Hung responder: abort at the wait limit
    send_cmd(1'b0, 6'd17, 32'h0, 4'b0101);
    serve(1000, 32'h0, 1'b0);
    take_rsp(0);

    // Response stalled while the next command is already waiting
    send_cmd(1'b1, 6'd33, 32'hCAFE_0001, 4'b1000);
    serve(1, 32'h0, 1'b0);
    cmd_write = 1'b0; cmd_addr = 6'd7; cmd_wdata = 32'h0; cmd_strobe = 4'b0000;
    cmd_valid = 1'b1;
    take_rsp(5);
    send_cmd(1'b0, 6'd7, 32'h0, 4'b0000);
    serve(0, 32'h0BAD_F00D, 1'b0);
    take_rsp(0);

    // Reset pulsed in the middle of ACCESS
    send_cmd(1'b1, 6'd21, 32'h1357_9BDF, 4'b1111);
    PREADY = 1'b0;
    @(negedge PCLK);
    check("pre_reset_access", 64'({PSEL, PENABLE}), 64'b11);
    #1 PRESET = 1'b1;
    #1 check("reset_async_drop", 64'({PSEL, PENABLE, rsp_valid}), 64'b000);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check("post_reset_idle", 64'({cmd_ready, rsp_valid, PSEL}), 64'b100);
    repeat (3) @(negedge PCLK);
    check("post_reset_no_rsp", 64'(rsp_valid), 64'd0);

    // Randomized transfers
    for (int n = 0; n < 24; n++) begin
      logic          w;
      logic          e;
      int            wt;
      w  = 1'($urandom_range(0, 1));
      e  = ($urandom_range(0, 3) == 0);
      wt = ($urandom_range(0, 7) == 0) ? TO + int'($urandom_range(0, 4)) : int'($urandom_range(0, 4));
      send_cmd(w, AW'($urandom), $urandom, SW'($urandom));
      serve(wt, e ? 32'h0 : $urandom, e);
      take_rsp(int'($urandom_range(0, 3)));
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
